// File: rtl/fib_pkg.sv
// Shared types and default widths for the Fibonacci term scheduler.
// The id-width helper keeps a single-requester build from collapsing to 0 bits.
package fib_pkg;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam int FIB_W     = 32;
   localparam int FIB_NW    = 16;
   localparam int FIB_N_REQ = 2;

   function automatic int id_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/fib_sched_if.sv
// Request/stream bundle between requesters, the scheduler and the term consumer.
import fib_pkg::*;
interface fib_sched_if #(
   parameter int W     = FIB_W,
   parameter int N_REQ = FIB_N_REQ,
   parameter int NW    = FIB_NW,
   parameter int IDW   = id_w(N_REQ)
);
   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ-1:0]         req_ready;
   logic [N_REQ-1:0][NW-1:0] req_n;
   logic                     out_valid;
   logic                     out_ready;
   logic [W-1:0]             out_data;
   logic [IDW-1:0]           out_id;
   logic                     out_last;
   logic                     out_ovf;
   logic                     busy;

   modport master (output req_valid, req_n, out_ready,
                   input  req_ready, out_valid, out_data, out_id, out_last, out_ovf, busy);
   modport slave  (input  req_valid, req_n, out_ready,
                   output req_ready, out_valid, out_data, out_id, out_last, out_ovf, busy);
endinterface

// File: rtl/fib_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
import fib_pkg::*;
module fib_rr_arb #(
   parameter int N_REQ = FIB_N_REQ,
   parameter int IDW   = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   input  logic             en,
   output logic [N_REQ-1:0] gnt,
   output logic [IDW-1:0]   idx
);
   logic           found;
   logic [IDW-1:0] k;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      k     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         k = IDW'((int'(ptr) + i) % N_REQ);
         if (en && !found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = k;
         end
      end
   end
endmodule

// File: rtl/fib_sched.sv
// Shares one Fibonacci term generator between N_REQ requesters, round-robin,
// streaming F(0)..F(n-1) tagged with the owning requester id.
import fib_pkg::*;
module fib_sched #(
   parameter int W     = FIB_W,
   parameter int N_REQ = FIB_N_REQ,
   parameter int NW    = FIB_NW,
   parameter int IDW   = id_w(N_REQ)
) (
   input logic       clk,
   input logic       reset,
   fib_sched_if.slave bus
);
   state_t           state, state_nx;
   logic [IDW-1:0]   ptr, id, g_idx;
   logic [N_REQ-1:0] gnt;
   logic [W-1:0]     a, b;
   logic             b_wrap, ovf;
   logic [NW-1:0]    cnt, n_r, n_sel;
   logic [W:0]       sum;
   logic             acc, xfer, last;

   fib_rr_arb #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
      .req (bus.req_valid),
      .ptr (ptr),
      .en  (state == IDLE),
      .gnt (gnt),
      .idx (g_idx)
   );

   assign acc   = |gnt;
   assign n_sel = bus.req_n[g_idx];
   assign xfer  = (state == RUN) && bus.out_ready;
   assign last  = (cnt == n_r - NW'(1));
   assign sum   = {1'b0, a} + {1'b0, b};

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (acc && n_sel != '0) state_nx = RUN;
         RUN:  if (xfer && last)       state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = gnt;
      bus.out_valid = (state == RUN);
      bus.busy      = (state == RUN);
      bus.out_data  = a;
      bus.out_id    = id;
      bus.out_last  = (state == RUN) && last;
      bus.out_ovf   = (state == RUN) && ovf;
   end

   // b_wrap tags b as a wrapped term; it folds into the sticky ovf once b is presented
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr    <= '0;
         id     <= '0;
         n_r    <= '0;
         cnt    <= '0;
         a      <= '0;
         b      <= W'(1);
         b_wrap <= 1'b0;
         ovf    <= 1'b0;
      end else if (acc) begin
         ptr    <= (g_idx == IDW'(N_REQ - 1)) ? '0 : g_idx + IDW'(1);
         id     <= g_idx;
         n_r    <= n_sel;
         cnt    <= '0;
         a      <= '0;
         b      <= W'(1);
         b_wrap <= 1'b0;
         ovf    <= 1'b0;
      end else if (xfer) begin
         a      <= b;
         b      <= sum[W-1:0];
         b_wrap <= sum[W];
         ovf    <= ovf | b_wrap;
         cnt    <= cnt + NW'(1);
      end
   end
endmodule
